// File: rtl/pipe_hazard_sched.sv
// Pipeline stall/flush scheduler: merges MEM wait, multi-cycle EX and load-use hazards into stall/flush vectors.
// Optional STALL_PERF_EN adds saturating per-cause stall counters (perf_mem, perf_ex, perf_lu).
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no multi-cycle EX op in flight
//   S_BUSY  | EX op in flight; cnt = remaining stall cycles before retire
module pipe_hazard_sched #(
   parameter int EX_LAT = 4,
   parameter int MEM_TO = 255
`ifdef STALL_PERF_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lu_req,
   input  logic             ex_start,
   input  logic             mem_wait,
   input  logic             br_taken,
   output logic [5:0]       stall,
   output logic [5:0]       flush,
   output logic             ex_done,
   output logic             ex_busy,
   output logic             mem_timeout
`ifdef STALL_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_mem,
   output logic [CNT_W-1:0] perf_ex,
   output logic [CNT_W-1:0] perf_lu
`endif
);

   localparam int CW = (EX_LAT > 2) ? $clog2(EX_LAT) : 1;
   localparam int MW = (MEM_TO > 1) ? $clog2(MEM_TO + 1) : 1;
   localparam logic [CW-1:0] CNT_START = CW'(EX_LAT - 2);
   localparam logic [MW-1:0] MEM_LIMIT = MW'(MEM_TO);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [MW-1:0] mem_to_cnt;
   logic          ex_stall;
   logic          done_raw;
   logic          timeout_q;
   logic [5:0]    stall_raw;
   logic [5:0]    flush_raw;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ex_stall  = 1'b0;
      done_raw  = 1'b0;
      case (state)
         S_IDLE: begin
            // a start under mem_wait is dropped; the held op re-requests next cycle
            if (ex_start && !mem_wait) begin
               ex_stall  = 1'b1;
               cnt_nxt   = CNT_START;
               state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt != '0) begin
               ex_stall = 1'b1;
               cnt_nxt  = cnt - CW'(1);
            end else if (!mem_wait) begin
               done_raw = 1'b1;
               if (ex_start) begin
                  ex_stall = 1'b1;
                  cnt_nxt  = CNT_START;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               ex_stall = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      stall_raw = 6'b000000;
      flush_raw = 6'b000000;
      if (mem_wait)      stall_raw = 6'b011111;
      else if (ex_stall) stall_raw = 6'b001111;
      else if (lu_req)   stall_raw = 6'b000111;
      for (int k = 0; k < 5; k++) begin
         flush_raw[k+1] = stall_raw[k] & ~stall_raw[k+1];
      end
      // a taken branch seen while ID is held is re-resolved once ID moves
      if (br_taken && !stall_raw[2]) flush_raw[2] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_to_cnt <= '0;
         timeout_q  <= 1'b0;
      end else begin
         if (!mem_wait)                     mem_to_cnt <= '0;
         else if (mem_to_cnt != MEM_LIMIT)  mem_to_cnt <= mem_to_cnt + MW'(1);
         if (mem_wait && mem_to_cnt == MEM_LIMIT) timeout_q <= 1'b1;
      end
   end

   assign stall       = reset ? 6'b000000 : stall_raw;
   assign flush       = reset ? 6'b000000 : flush_raw;
   assign ex_done     = ~reset & done_raw;
   assign ex_busy     = ~reset & (state == S_BUSY);
   assign mem_timeout = ~reset & timeout_q;

`ifdef STALL_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_mem <= '0;
         perf_ex  <= '0;
         perf_lu  <= '0;
      end else begin
         if (mem_wait && !(&perf_mem)) perf_mem <= perf_mem + CNT_W'(1);
         if (!mem_wait && ex_stall && !(&perf_ex)) perf_ex <= perf_ex + CNT_W'(1);
         if (!mem_wait && !ex_stall && lu_req && !(&perf_lu)) perf_lu <= perf_lu + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Bench for pipe_hazard_sched: expected per-cycle outputs queued at drive time, compared on the falling edge.
module tb_pipe_hazard_sched;

   logic       clk = 1'b0;
   logic       reset, lu_req, ex_start, mem_wait, br_taken;
   logic [5:0] stall, flush;
   logic       ex_done, ex_busy, mem_timeout;
`ifdef STALL_PERF_EN
   logic [15:0] perf_mem, perf_ex, perf_lu;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [5:0] st;
      logic [5:0] fl;
      logic       d;
      logic       b;
   } exp_t;
   exp_t exp_q[$];

   pipe_hazard_sched #(.EX_LAT(4), .MEM_TO(255)) dut (
      .clk(clk), .reset(reset), .lu_req(lu_req), .ex_start(ex_start),
      .mem_wait(mem_wait), .br_taken(br_taken), .stall(stall), .flush(flush),
      .ex_done(ex_done), .ex_busy(ex_busy), .mem_timeout(mem_timeout)
`ifdef STALL_PERF_EN
      , .perf_mem(perf_mem), .perf_ex(perf_ex), .perf_lu(perf_lu)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if ({stall, flush, ex_done, ex_busy} !== {e.st, e.fl, e.d, e.b}) begin
            errors++;
            $display("FAIL %s: got stall=%b flush=%b done=%b busy=%b, expected stall=%b flush=%b done=%b busy=%b",
                     e.name, stall, flush, ex_done, ex_busy, e.st, e.fl, e.d, e.b);
         end
      end
   end

   // one clock cycle of stimulus; chk queues the expected outputs for this cycle
   task automatic step(input logic rst, input logic lu, input logic ex, input logic mw,
                       input logic br, input logic chk, input string nm,
                       input logic [5:0] st, input logic [5:0] fl, input logic d, input logic b);
      @(posedge clk);
      #1;
      reset = rst; lu_req = lu; ex_start = ex; mem_wait = mw; br_taken = br;
      if (chk) begin
         exp_t e;
         e.name = nm; e.st = st; e.fl = fl; e.d = d; e.b = b;
         exp_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      step(1, 1, 1, 1, 1, 1, "reset_forced", 6'b000000, 6'b000000, 0, 0);
      step(1, 0, 0, 0, 0, 1, "reset_hold",   6'b000000, 6'b000000, 0, 0);
      step(0, 0, 0, 0, 0, 1, "reset_idle",   6'b000000, 6'b000000, 0, 0);
      checks++;
      if (mem_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_timeout: got %b expected 0", mem_timeout);
      end
   endtask

   task automatic test_ex();
      step(0, 0, 1, 0, 0, 1, "ex_t0",   6'b001111, 6'b010000, 0, 0);
      step(0, 0, 0, 0, 0, 1, "ex_t1",   6'b001111, 6'b010000, 0, 1);
      step(0, 0, 0, 0, 0, 1, "ex_t2",   6'b001111, 6'b010000, 0, 1);
      step(0, 0, 0, 0, 0, 1, "ex_done", 6'b000000, 6'b000000, 1, 1);
      step(0, 0, 0, 0, 0, 1, "ex_idle", 6'b000000, 6'b000000, 0, 0);
`ifdef STALL_PERF_EN
      checks++;
      if (perf_ex !== 16'd3) begin
         errors++;
         $display("FAIL perf_ex: got %0d expected 3", perf_ex);
      end
`endif
   endtask

   task automatic test_lu();
      step(0, 1, 0, 0, 0, 1, "lu_stall", 6'b000111, 6'b001000, 0, 0);
      step(0, 0, 0, 0, 0, 1, "lu_clear", 6'b000000, 6'b000000, 0, 0);
   endtask

   task automatic test_branch();
      step(0, 1, 0, 0, 1, 1, "br_with_lu", 6'b000111, 6'b001000, 0, 0);
      step(0, 0, 0, 0, 1, 1, "br_alone",   6'b000000, 6'b000100, 0, 0);
      step(0, 0, 1, 0, 1, 1, "br_with_ex", 6'b001111, 6'b010000, 0, 0);
      step(0, 0, 0, 0, 0, 1, "br_ex_t1",   6'b001111, 6'b010000, 0, 1);
      step(0, 0, 0, 0, 0, 1, "br_ex_t2",   6'b001111, 6'b010000, 0, 1);
      step(0, 0, 0, 0, 0, 1, "br_ex_done", 6'b000000, 6'b000000, 1, 1);
   endtask

   task automatic test_ex_mem();
      step(0, 0, 1, 1, 0, 1, "start_under_mw", 6'b011111, 6'b100000, 0, 0);
      step(0, 0, 0, 0, 0, 1, "start_dropped",  6'b000000, 6'b000000, 0, 0);
      step(0, 0, 1, 0, 0, 1, "exm_t0", 6'b001111, 6'b010000, 0, 0);
      for (int i = 1; i <= 4; i++)
         step(0, 0, 0, 1, 0, 1, $sformatf("exm_mw%0d", i), 6'b011111, 6'b100000, 0, 1);
      step(0, 0, 0, 0, 0, 1, "exm_done", 6'b000000, 6'b000000, 1, 1);
      step(0, 0, 0, 0, 0, 1, "exm_idle", 6'b000000, 6'b000000, 0, 0);
   endtask

   task automatic test_back_to_back();
      step(0, 0, 1, 0, 0, 1, "b2b_t0",     6'b001111, 6'b010000, 0, 0);
      step(0, 0, 1, 0, 0, 1, "b2b_t1",     6'b001111, 6'b010000, 0, 1);
      step(0, 0, 1, 0, 0, 1, "b2b_t2",     6'b001111, 6'b010000, 0, 1);
      step(0, 0, 1, 0, 0, 1, "b2b_restart", 6'b001111, 6'b010000, 1, 1);
      step(0, 0, 0, 0, 0, 1, "b2b_r1",     6'b001111, 6'b010000, 0, 1);
      step(0, 1, 0, 0, 0, 1, "b2b_r2_lu",  6'b001111, 6'b010000, 0, 1);
      step(0, 0, 0, 0, 0, 1, "b2b_done2",  6'b000000, 6'b000000, 1, 1);
      step(0, 0, 0, 0, 0, 1, "b2b_idle",   6'b000000, 6'b000000, 0, 0);
   endtask

   task automatic test_timeout();
      step(0, 0, 0, 1, 0, 1, "to_first", 6'b011111, 6'b100000, 0, 0);
      for (int i = 2; i <= 255; i++)
         step(0, 0, 0, 1, 0, 0, "", 6'b0, 6'b0, 0, 0);
      step(0, 0, 0, 1, 0, 1, "to_256th", 6'b011111, 6'b100000, 0, 0);
      checks++;
      if (mem_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: got %b expected 0 after 255 wait cycles", mem_timeout);
      end
      step(0, 0, 0, 0, 0, 1, "to_release", 6'b000000, 6'b000000, 0, 0);
      checks++;
      if (mem_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_set: got %b expected 1", mem_timeout);
      end
      step(0, 0, 0, 0, 0, 0, "", 6'b0, 6'b0, 0, 0);
      step(0, 0, 0, 0, 0, 0, "", 6'b0, 6'b0, 0, 0);
      checks++;
      if (mem_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: got %b expected 1", mem_timeout);
      end
   endtask

   task automatic test_reset_mid_op();
      step(0, 0, 1, 0, 0, 1, "rmo_t0",    6'b001111, 6'b010000, 0, 0);
      step(1, 0, 0, 0, 0, 1, "rmo_reset", 6'b000000, 6'b000000, 0, 0);
      step(0, 0, 0, 0, 0, 1, "rmo_idle",  6'b000000, 6'b000000, 0, 0);
      step(0, 0, 0, 0, 0, 1, "rmo_nodone", 6'b000000, 6'b000000, 0, 0);
      checks++;
      if (mem_timeout !== 1'b0) begin
         errors++;
         $display("FAIL rmo_timeout_cleared: got %b expected 0", mem_timeout);
      end
   endtask

   initial begin
      reset = 1'b1; lu_req = 1'b0; ex_start = 1'b0; mem_wait = 1'b0; br_taken = 1'b0;
      test_reset();
      test_ex();
      test_lu();
      test_branch();
      test_ex_mem();
      test_back_to_back();
      test_timeout();
      test_reset_mid_op();
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
